// File: rtl/md_seq_engine.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) engine, 32 bits.
// Optional macro MD_DIVZERO_EXC_EN: divide by zero completes next cycle with div_zero set.
module md_seq_engine #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] qr_q, qr_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   opd_q, opd_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MD_DIVZERO_EXC_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   booth_sum, booth_acc;
    logic [WIDTH-1:0] booth_q;
    logic [WIDTH:0]   rem_sh, trial, div_acc;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    // Booth: acc holds the 33-bit partial product so -M of the most negative value fits.
    always_comb begin
        abs_a = a[WIDTH-1] ? ('0 - a) : a;
        abs_b = b[WIDTH-1] ? ('0 - b) : b;

        case ({qr_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + opd_q;
            2'b10:   booth_sum = acc_q - opd_q;
            default: booth_sum = acc_q;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q   = {booth_sum[0], qr_q[WIDTH-1:1]};

        rem_sh = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
        trial  = rem_sh - opd_q;
        if (!trial[WIDTH]) begin
            div_acc = trial;
            div_q   = {qr_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = rem_sh;
            div_q   = {qr_q[WIDTH-2:0], 1'b0};
        end

        quot_fix = negq_q ? ('0 - qr_q) : qr_q;
        rem_fix  = negr_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        qm1_d   = qm1_q;
        opd_d   = opd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MD_DIVZERO_EXC_EN
        dz_d    = dz_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    if (!op) begin
                        qr_d    = b;
                        opd_d   = {a[WIDTH-1], a};
                        state_d = S_MULT;
                    end else begin
                        qr_d    = abs_a;
                        opd_d   = {1'b0, abs_b};
                        // Zero divisor keeps the all-ones quotient unsigned.
                        negq_d  = (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
                        negr_d  = a[WIDTH-1];
                        state_d = S_DIV;
`ifdef MD_DIVZERO_EXC_EN
                        if (b == '0) begin
                            dz_d    = 1'b1;
                            state_d = S_DONE;
                        end
`endif
                    end
                end
            end
            S_MULT: begin
                acc_d = booth_acc;
                qr_d  = booth_q;
                qm1_d = qr_q[0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = booth_acc[WIDTH-1:0];
                    lo_d    = booth_q;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_acc;
                qr_d  = div_q;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = rem_fix;
                lo_d    = quot_fix;
                state_d = S_DONE;
            end
            S_DONE: begin
`ifdef MD_DIVZERO_EXC_EN
                dz_d    = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            opd_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MD_DIVZERO_EXC_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            qm1_q   <= qm1_d;
            opd_q   <= opd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MD_DIVZERO_EXC_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MD_DIVZERO_EXC_EN
    assign div_zero = (state_q == S_DONE) && dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_md_seq_engine.sv
// Self-checking bench for md_seq_engine: cycle-level result/latency model plus directed literal checks.
module tb_md_seq_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    md_seq_engine #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_cnt = edges since acceptance (0 = idle), result lands when m_cnt reaches m_lat.
    int          m_cnt = 0;
    int          m_lat = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] p_hi = '0, p_lo = '0;
    bit          p_dz = 1'b0;

    task automatic predict(input logic [31:0] ta, input logic [31:0] tb, input logic top);
        longint sa, sb, prod, q, r;
        sa = longint'($signed(ta));
        sb = longint'($signed(tb));
        p_dz = 1'b0;
        if (!top) begin
            prod  = sa * sb;
            p_hi  = prod[63:32];
            p_lo  = prod[31:0];
            m_lat = 33;
        end else if (tb == 32'd0) begin
`ifdef MD_DIVZERO_EXC_EN
            p_dz  = 1'b1;
            p_hi  = m_hi;
            p_lo  = m_lo;
            m_lat = 1;
`else
            p_hi  = ta;
            p_lo  = 32'hFFFF_FFFF;
            m_lat = 34;
`endif
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            p_hi  = r[31:0];
            p_lo  = q[31:0];
            m_lat = 34;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0;
            m_hi  = '0;
            m_lo  = '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                predict(a, b, op);
                m_cnt = 1;
                if (m_lat == 1) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (m_cnt == m_lat) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == m_lat) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_cnt > 0 && m_cnt < m_lat));
            chk("done", 64'(done), 64'(m_cnt != 0 && m_cnt == m_lat));
            chk("div_zero", 64'(div_zero), 64'(m_cnt != 0 && m_cnt == m_lat && p_dz));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                          input int exp_lat, input bit lit, input logic [31:0] ehi,
                          input logic [31:0] elo, input bit edz, input bit start_on_done);
        int k;
        bit got;
        @(posedge clk); #1;
        a = ta; b = tb; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 1'($urandom);
        k = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                k = i;
            end
        end
        chk("latency", 64'(k), 64'(exp_lat));
        if (lit) begin
            chk("lit_hi", 64'(hi), 64'(ehi));
            chk("lit_lo", 64'(lo), 64'(elo));
            chk("lit_div_zero", 64'(div_zero), 64'(edz));
        end
        if (start_on_done) begin
            a = 32'd9; b = 32'd4; op = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("start_on_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int seen;
        logic [31:0] keep_hi, keep_lo;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        run_op(32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 33, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 33, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 33, 1'b1, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op(32'd12345, 32'hFFFF_E57B, 1'b0, 33, 1'b0, '0, '0, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h1234_5678, 1'b0, 33, 1'b0, '0, '0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 34, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(32'd100, 32'd7, 1'b1, 34, 1'b1, 32'd2, 32'd14, 1'b0, 1'b0);
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 34, 1'b1, 32'hFFFF_FFFE, 32'd14, 1'b0, 1'b0);
        run_op(32'd7, 32'hFFFF_FF9C, 1'b1, 34, 1'b1, 32'd7, 32'd0, 1'b0, 1'b0);
        run_op(32'd0, 32'd5, 1'b1, 34, 1'b0, '0, '0, 1'b0, 1'b0);
        keep_hi = m_hi;
        keep_lo = m_lo;
`ifdef MD_DIVZERO_EXC_EN
        run_op(32'd5, 32'd0, 1'b1, 1, 1'b1, keep_hi, keep_lo, 1'b1, 1'b0);
`else
        run_op(32'd5, 32'd0, 1'b1, 34, 1'b1, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif

        // Reset mid-multiply with an ignored start pulse while busy.
        @(posedge clk); #1;
        a = 32'd7; b = 32'd3; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("no_done_after_abort", 64'(seen), 64'd0);

        run_op(32'h0000_0003, 32'hFFFF_FFFE, 1'b0, 33, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/md_seq_engine.md
MD_SEQ_ENGINE -- requirements
Module: md_seq_engine

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 op  input  1  operation select: 0 = signed multiply, 1 = signed divide.
REQ-006 a  input  32  multiplicand / dividend (REG_A value).
REQ-007 b  input  32  multiplier / divisor (REG_B value).
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse, results valid.
REQ-010 hi  output  32  product upper word / division remainder, feeds HI register.
REQ-011 lo  output  32  product lower word / division quotient, feeds LO register.
REQ-012 div_zero  output  1  divide-by-zero flag; pulses with done.

Function
REQ-013 FSM states: IDLE, MULT, DIV, FIX, DONE.
REQ-014 IDLE: start=1 captures a, b, op at that edge (edge N), then goes to MULT (op=0) or DIV (op=1).
REQ-015 Operands are held internally from edge N on; later changes on a/b/op have no effect.
REQ-016 MULT: radix-2 Booth, one iteration per cycle, 32 iterations, then DONE.
REQ-017 DIV: restoring division on magnitudes, one quotient bit per cycle, 32 iterations, then FIX.
REQ-018 FIX: quotient negated if operand signs differ; remainder takes dividend sign; then DONE.
REQ-019 Multiply latency: done high in cycle N+33.
REQ-020 Divide latency: done high in cycle N+34.
REQ-021 DONE: done=1 for exactly one cycle; busy=0; return to IDLE next edge.
REQ-022 busy=1 in MULT, DIV, FIX; 0 in IDLE and DONE.
REQ-023 hi/lo update only on entry to DONE; they hold their value until the next completion.
REQ-024 Multiply result is the full signed 64-bit product {hi,lo}.
REQ-025 0x80000000 / 0xFFFFFFFF yields lo=0x80000000 (wrap) and hi=0.
REQ-026 start while busy or in DONE is ignored; no queuing.
REQ-027 start asserted in the same cycle that done pulses is ignored.

Reset
REQ-028 rst=0 forces, asynchronously, state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, and clears internal operands and counter.
REQ-029 Reset mid-operation aborts the operation; no done pulse follows.

Configuration
REQ-030 The macro MD_DIVZERO_EXC_EN selects divide-by-zero handling.
REQ-031 MD_DIVZERO_EXC_EN defined: a divide with b=0 skips the iterations; done=1 and div_zero=1 in cycle N+1; hi/lo unchanged.
REQ-032 MD_DIVZERO_EXC_EN undefined: div_zero tied 0; a divide with b=0 takes the normal N+34 latency with hi=a, lo=0xFFFFFFFF.

Verification
REQ-033 Multiply 0x00000007 x 0xFFFFFFFD -> done at N+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high N+1..N+32.
REQ-034 Multiply 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 Divide 0xFFFFFFF9 / 0x00000002 -> done at N+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 Divide 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-037 Divide 0x00000005 / 0 -> with macro: done and div_zero at N+1, hi/lo unchanged; without macro: done at N+34, hi=0x00000005, lo=0xFFFFFFFF.
REQ-038 rst low at N+10 of a multiply, start pulsed at N+5 -> busy=0, hi=lo=0, no done pulse; the start at N+5 is ignored.
